uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
- Receives asynchronous 8N1 UART serial data on the rx pin and produces one byte per frame with a single-cycle push strobe.
- Sits directly upstream of the UART receive word-assembly FIFO: push_o/data_o drive that FIFO's push/write_data.
- Rejects glitch starts, checks the stop bit and reports framing errors without pushing bad bytes.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD_RATE, 115_200, serial bit rate in baud.
- DATA_BITS, 8, data bits per frame, sent LSB first.
- CLKS_PER_BIT (localparam), CLK_FREQ / BAUD_RATE with integer truncation. Elaboration fails if the result is below 4.
- HALF_BIT (localparam), CLKS_PER_BIT / 2 with truncation.

Ports:
- clk  input  1  system clock; all logic on posedge.
- arst  input  1  asynchronous reset, active-high.
- rx  input  1  serial line, asynchronous to clk; idles high.
- data_o  output  DATA_BITS  last correctly received byte; holds until the next good frame.
- push_o  output  1  one-cycle strobe: data_o is valid and new.
- frame_err_o  output  1  one-cycle strobe: stop bit sampled low.
- busy_o  output  1  high in every state except IDLE.

Behaviour:
- Reset (arst high, asynchronous):
  - state = IDLE; both synchronizer flops = 1; bit and cycle counters = 0.
  - data_o = 0, push_o = 0, frame_err_o = 0, busy_o = 0.
  - Reset mid-frame aborts the frame: no push, no error.
  - After reset release, the block needs a fresh falling edge on rx to start.
- Input path:
  - rx passes through a 2-flop synchronizer (rx_s).
  - A start is detected when rx_s = 0 while in IDLE. Because the synchronizer resets to 1, no false start follows reset.
- Cycle counter:
  - Width is $clog2(CLKS_PER_BIT).
  - Cleared on every state entry and after each sample.
- State machine:
  - IDLE:
    - On rx_s = 0, go to START and clear the counter.
  - START:
    - Counts to HALF_BIT-1, then samples rx_s.
    - rx_s = 1: glitch; return to IDLE with no outputs.
    - rx_s = 0: go to DATA with bit index 0.
  - DATA:
    - Every CLKS_PER_BIT cycles, sample rx_s into shift register bit [index]. Data is LSB first.
    - After bit DATA_BITS-1 is sampled, go to STOP.
  - STOP:
    - After CLKS_PER_BIT cycles, sample rx_s.
    - rx_s = 1: on the next edge, data_o takes the shift register and push_o = 1 for exactly one cycle. Go to IDLE.
    - rx_s = 0: frame_err_o = 1 for one cycle; data_o is unchanged and push_o stays 0. Go to WAIT_IDLE.
  - WAIT_IDLE:
    - Stays here (break condition) until rx_s = 1, then goes to IDLE.
    - Prevents a held-low line from being taken as repeated starts.
- Timing:
  - Each sample point is centred in its bit.
  - With rx driven synchronously to clk, push_o rises exactly 2 + HALF_BIT + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles after the clk edge at which rx first goes low.
  - For a hardware (asynchronous) rx, the bench tolerance is ±1 cycle.
- Back-to-back frames:
  - The block is back in IDLE by mid-stop-bit, so a start edge arriving at the nominal end of the stop bit is caught.
  - No gap between frames is required.
- push_o and frame_err_o are never high in the same cycle.
- busy_o is 1 in START, DATA, STOP and WAIT_IDLE, including the push/error cycle.
- There is no back-pressure: the downstream FIFO must accept every push.

Test Plan:
(Bench uses CLK_FREQ=16, BAUD_RATE=1, so CLKS_PER_BIT=16 and HALF_BIT=8. rx is driven synchronously.)
- Reset then idle line high for 200 cycles -> push_o, frame_err_o and busy_o stay 0; data_o = 0x00.
- Send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> single push_o pulse exactly 2+8+144+1 = 155 cycles after rx falls; data_o = 0xA5 held afterwards.
- Send 0x3C, then 0xFF immediately with no idle gap, then 0x00 -> three pushes, data 0x3C, 0xFF, 0x00 in order; pushes spaced 160 cycles apart; no frame_err_o.
- rx low pulse of 4 cycles, then high -> START returns to IDLE; no push, no error; busy_o high for about 8 cycles only.
- Frame 0x55 with stop bit held 0, and rx kept low 100 more cycles, then a valid 0x12 -> one frame_err_o pulse; data_o stays at its prior value; no push while rx is low; then push with data_o = 0x12.
- Assert arst in the middle of data bit 4 of frame 0x81, release it, then send 0x7E -> no push for the aborted frame; outputs are 0 during reset; next push carries 0x7E.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: synchronizes rx, samples each bit at its centre and
// emits one byte per good frame with a push strobe or a framing-error strobe.
module uart_rx_deserializer #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 115_200,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 push_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST    = BW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_bad_baud
    $error("CLKS_PER_BIT must be at least 4");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t state, state_nx;

  logic                 rx_m, rx_s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 cnt_clr, idx_clr, take, good, bad;
  logic                 tick_half, tick_bit;

  assign tick_half = (cnt == HALF_M1);
  assign tick_bit  = (cnt == BIT_M1);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    idx_clr  = 1'b0;
    take     = 1'b0;
    good     = 1'b0;
    bad      = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_nx = START;
      end
      START: begin
        if (tick_half) begin
          cnt_clr  = 1'b1;
          idx_clr  = 1'b1;
          state_nx = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_bit) begin
          cnt_clr = 1'b1;
          take    = 1'b1;
          if (idx == LAST) state_nx = STOP;
        end
      end
      STOP: begin
        if (tick_bit) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            good     = 1'b1;
            state_nx = IDLE;
          end else begin
            bad      = 1'b1;
            state_nx = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_clr = 1'b1;
        if (rx_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      if (idx_clr)   idx <= '0;
      else if (take) idx <= idx + 1'b1;
      if (take) shreg[idx] <= rx_s;
    end
  end

  // Strobes are registered at the stop-bit sample edge, so busy_o also
  // covers the cycle after the FSM has already returned to IDLE.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      data_o      <= '0;
      push_o      <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      push_o      <= good;
      frame_err_o <= bad;
      if (good) data_o <= shreg;
    end
  end

  assign busy_o = (state != IDLE) | push_o | frame_err_o;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench for uart_rx_deserializer at 16 clocks per bit
// with rx driven one delta after the clock edge.
module tb_uart_rx_deserializer;

  localparam int CPB = 16;
  localparam int LAT = 155;

  logic       clk  = 1'b0;
  logic       arst = 1'b1;
  logic       rx   = 1'b1;
  logic [7:0] data_o;
  logic       push_o, frame_err_o, busy_o;

  int cyc      = 0;
  int passed   = 0;
  int total    = 0;
  int busy_cnt = 0;
  int both_cnt = 0;
  int         pt[$];
  logic [7:0] pd[$];
  int         et[$];

  uart_rx_deserializer #(
    .CLK_FREQ (16),
    .BAUD_RATE(1),
    .DATA_BITS(8)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .rx         (rx),
    .data_o     (data_o),
    .push_o     (push_o),
    .frame_err_o(frame_err_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (push_o) begin
      pt.push_back(cyc);
      pd.push_back(data_o);
    end
    if (frame_err_o) et.push_back(cyc);
    if (busy_o) busy_cnt++;
    if (push_o && frame_err_o) both_cnt++;
  end

  task automatic clear_mon();
    pt.delete();
    pd.delete();
    et.delete();
    busy_cnt = 0;
  endtask

  // Called at posedge+1; returns at posedge+1 at the nominal end of stop.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    rx   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({push_o, frame_err_o, busy_o, data_o} !== 11'h0)
      $display("FAIL reset_outputs: got %b/%b/%b/%h want 0/0/0/00",
               push_o, frame_err_o, busy_o, data_o);
    else passed++;
    @(posedge clk);
    #1;
    arst = 1'b0;
    clear_mon();
    repeat (200) @(posedge clk);
    @(negedge clk);
    total++;
    if (pt.size() != 0 || et.size() != 0)
      $display("FAIL idle_strobes: pushes %0d errs %0d want 0 0",
               pt.size(), et.size());
    else passed++;
    total++;
    if (busy_cnt != 0)
      $display("FAIL idle_busy: busy cycles %0d want 0", busy_cnt);
    else passed++;
    total++;
    if (data_o !== 8'h00)
      $display("FAIL idle_data: got %h want 00", data_o);
    else passed++;
  endtask

  task automatic test_single();
    int t0, d;
    clear_mon();
    @(posedge clk);
    #1;
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++;
    if (pt.size() != 1)
      $display("FAIL single_count: pushes %0d want 1", pt.size());
    else passed++;
    d = (pt.size() > 0) ? pt[0] - t0 : -1;
    total++;
    if (d != LAT)
      $display("FAIL single_latency: got %0d want %0d", d, LAT);
    else passed++;
    total++;
    if (data_o !== 8'hA5)
      $display("FAIL single_data: got %h want a5", data_o);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int t0;
    logic [7:0] exp [3];
    exp[0] = 8'h3C;
    exp[1] = 8'hFF;
    exp[2] = 8'h00;
    clear_mon();
    @(posedge clk);
    #1;
    t0 = cyc;
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++;
    if (pt.size() != 3)
      $display("FAIL b2b_count: pushes %0d want 3", pt.size());
    else passed++;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] got;
      int         tm;
      got = (pt.size() > i) ? pd[i] : 8'hxx;
      tm  = (pt.size() > i) ? pt[i] - t0 : -1;
      total++;
      if (got !== exp[i])
        $display("FAIL b2b_data%0d: got %h want %h", i, got, exp[i]);
      else passed++;
      total++;
      if (tm != LAT + 160 * i)
        $display("FAIL b2b_time%0d: got %0d want %0d", i, tm, LAT + 160 * i);
      else passed++;
    end
    total++;
    if (et.size() != 0)
      $display("FAIL b2b_err: errs %0d want 0", et.size());
    else passed++;
  endtask

  task automatic test_glitch();
    clear_mon();
    @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    total++;
    if (pt.size() != 0 || et.size() != 0)
      $display("FAIL glitch_strobes: pushes %0d errs %0d want 0 0",
               pt.size(), et.size());
    else passed++;
    total++;
    if (busy_cnt < 7 || busy_cnt > 9)
      $display("FAIL glitch_busy: busy cycles %0d want 8", busy_cnt);
    else passed++;
  endtask

  task automatic test_framing();
    int t0, d;
    clear_mon();
    @(posedge clk);
    #1;
    t0 = cyc;
    send_frame(8'h55, 1'b0);
    @(negedge clk);
    d = (et.size() > 0) ? et[0] - t0 : -1;
    total++;
    if (d != LAT)
      $display("FAIL ferr_time: got %0d want %0d", d, LAT);
    else passed++;
    total++;
    if (data_o !== 8'h00)
      $display("FAIL ferr_data_hold: got %h want 00", data_o);
    else passed++;
    repeat (100) @(posedge clk);
    @(negedge clk);
    total++;
    if (pt.size() != 0 || et.size() != 1)
      $display("FAIL ferr_break: pushes %0d errs %0d want 0 1",
               pt.size(), et.size());
    else passed++;
    total++;
    if (busy_o !== 1'b1)
      $display("FAIL ferr_busy: got %b want 1", busy_o);
    else passed++;
    @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    t0 = cyc;
    send_frame(8'h12, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    d = (pt.size() > 0) ? pt[0] - t0 : -1;
    total++;
    if (pt.size() != 1 || d != LAT)
      $display("FAIL ferr_recover: pushes %0d latency %0d want 1 %0d",
               pt.size(), d, LAT);
    else passed++;
    total++;
    if (data_o !== 8'h12)
      $display("FAIL ferr_recover_data: got %h want 12", data_o);
    else passed++;
  endtask

  task automatic test_reset_midframe();
    int t0, d;
    logic [7:0] b;
    b = 8'h81;
    clear_mon();
    @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    rx = b[4];
    repeat (8) @(posedge clk);
    #1;
    arst = 1'b1;
    rx   = 1'b1;
    @(negedge clk);
    total++;
    if ({push_o, frame_err_o, busy_o, data_o} !== 11'h0)
      $display("FAIL midrst_outputs: got %b/%b/%b/%h want 0/0/0/00",
               push_o, frame_err_o, busy_o, data_o);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    arst = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    total++;
    if (pt.size() != 0 || et.size() != 0)
      $display("FAIL midrst_abort: pushes %0d errs %0d want 0 0",
               pt.size(), et.size());
    else passed++;
    @(posedge clk);
    #1;
    t0 = cyc;
    send_frame(8'h7E, 1'b1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    d = (pt.size() > 0) ? pt[0] - t0 : -1;
    total++;
    if (pt.size() != 1 || d != LAT)
      $display("FAIL midrst_next: pushes %0d latency %0d want 1 %0d",
               pt.size(), d, LAT);
    else passed++;
    total++;
    if (data_o !== 8'h7E)
      $display("FAIL midrst_data: got %h want 7e", data_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_midframe();
    total++;
    if (both_cnt != 0)
      $display("FAIL strobe_overlap: cycles %0d want 0", both_cnt);
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
